muldiv_ctrl: RTL and testbench

Sequencer for the multicycle CPU's multiply and divide units. It accepts MULT/DIV requests from the main control unit and issues a one-cycle start pulse to the selected unit. It waits for that unit's stop flag, then latches the 64-bit result into the architectural HI/LO registers. It also provides MTHI/MTLO writes, a busy/stall signal, divide-by-zero detection and a watchdog timeout.

---
 rtl/muldiv_ctrl.sv | 162 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the multicycle CPU's multiply and divide units.
//
// Accepts a MULT/DIV request in IDLE and sends a one-cycle start pulse to the
// selected unit. It then waits for that unit's stop flag and latches the
// 64-bit result into the architectural HI/LO registers. MTHI/MTLO writes are
// accepted only in IDLE. A divide by zero is rejected without starting the
// divider. A watchdog bounds the wait for the stop flag.
//
// Ports
//   Clock, Reset                 system clock; synchronous active-low reset
//   w_OpValid, w_OpSel           request strobe (IDLE only); 0 = MULT, 1 = DIV
//   w_B                          divisor operand, used for the zero check
//   w_HIWrite, w_LOWrite         MTHI / MTLO strobes
//   w_WData                      MTHI / MTLO data
//   w_MultStart, w_MultStop      multiplier handshake
//   w_MULTHI, w_MULTLO           multiplier result
//   w_DivStart, w_DivStop        divider handshake
//   w_DIVHI, w_DIVLO             divider remainder / quotient
//   w_HI, w_LO                   architectural HI/LO registers
//   w_Busy                       pipeline stall (state != IDLE)
//   w_Done, w_DivZero, w_Timeout one-cycle status pulses
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; MTHI/MTLO are applied here
// START | one-cycle start pulse to the selected unit; watchdog cleared
// WAIT  | waiting for the selected unit's stop flag; watchdog counting
// DONE  | HI/LO hold the new result; w_Done pulsed
// ERR   | divide by zero or watchdog expiry; matching pulse raised
//
// All outputs are registered. Each one is computed from the next state, so
// its value lines up with the state it describes.

module muldiv_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        w_OpValid,
  input  logic        w_OpSel,
  input  logic [31:0] w_B,
  input  logic        w_HIWrite,
  input  logic        w_LOWrite,
  input  logic [31:0] w_WData,
  output logic        w_MultStart,
  input  logic        w_MultStop,
  input  logic [31:0] w_MULTHI,
  input  logic [31:0] w_MULTLO,
  output logic        w_DivStart,
  input  logic        w_DivStop,
  input  logic [31:0] w_DIVHI,
  input  logic [31:0] w_DIVLO,
  output logic [31:0] w_HI,
  output logic [31:0] w_LO,
  output logic        w_Busy,
  output logic        w_Done,
  output logic        w_DivZero,
  output logic        w_Timeout
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_d, lo_d;
  logic          divzero_d, timeout_d;
  logic          stop_sel;

  // Only the selected unit's stop flag matters; the other one is ignored.
  assign stop_sel = sel_q ? w_DivStop : w_MultStop;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    hi_d      = w_HI;
    lo_d      = w_LO;
    divzero_d = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A direct write in the same cycle as an accepted request still
        // lands; a successful operation overwrites it later.
        if (w_HIWrite) hi_d = w_WData;
        if (w_LOWrite) lo_d = w_WData;
        if (w_OpValid) begin
          if (w_OpSel && (w_B == 32'd0)) begin
            state_d   = S_ERR;
            divzero_d = 1'b1;
          end else begin
            sel_d   = w_OpSel;
            state_d = S_START;
          end
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // When stop arrives in the last allowed cycle, stop takes
        // priority over the watchdog.
        if (stop_sel) begin
          hi_d    = sel_q ? w_DIVHI : w_MULTHI;
          lo_d    = sel_q ? w_DIVLO : w_MULTLO;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_ERR;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      w_HI        <= '0;
      w_LO        <= '0;
      w_MultStart <= 1'b0;
      w_DivStart  <= 1'b0;
      w_Busy      <= 1'b0;
      w_Done      <= 1'b0;
      w_DivZero   <= 1'b0;
      w_Timeout   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      w_HI        <= hi_d;
      w_LO        <= lo_d;
      w_MultStart <= (state_d == S_START) && !sel_d;
      w_DivStart  <= (state_d == S_START) && sel_d;
      w_Busy      <= (state_d != S_IDLE);
      w_Done      <= (state_d == S_DONE);
      w_DivZero   <= divzero_d;
      w_Timeout   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl. A transaction-level reference predicts, for each
// request, the outcome (result, divide-by-zero or timeout), the final HI/LO
// contents, and the cycle on which each pulse appears. A mock unit returns
// its stop flag a chosen number of cycles after it sees the start pulse.
// Stray requests, MTHI/MTLO writes and foreign stop flags are injected while
// the controller is busy.

module tb_muldiv_ctrl;

  localparam int TIMEOUT = 40;
  localparam int BUDGET  = 60;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        w_OpValid, w_OpSel;
  logic [31:0] w_B;
  logic        w_HIWrite, w_LOWrite;
  logic [31:0] w_WData;
  logic        w_MultStart, w_MultStop;
  logic [31:0] w_MULTHI, w_MULTLO;
  logic        w_DivStart, w_DivStop;
  logic [31:0] w_DIVHI, w_DIVLO;
  logic [31:0] w_HI, w_LO;
  logic        w_Busy, w_Done, w_DivZero, w_Timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference copy of the architectural HI/LO registers.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset),
    .w_OpValid(w_OpValid), .w_OpSel(w_OpSel), .w_B(w_B),
    .w_HIWrite(w_HIWrite), .w_LOWrite(w_LOWrite), .w_WData(w_WData),
    .w_MultStart(w_MultStart), .w_MultStop(w_MultStop),
    .w_MULTHI(w_MULTHI), .w_MULTLO(w_MULTLO),
    .w_DivStart(w_DivStart), .w_DivStop(w_DivStop),
    .w_DIVHI(w_DIVHI), .w_DIVLO(w_DIVLO),
    .w_HI(w_HI), .w_LO(w_LO),
    .w_Busy(w_Busy), .w_Done(w_Done), .w_DivZero(w_DivZero), .w_Timeout(w_Timeout)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, limit 2000000 ns");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic quiet_inputs();
    w_OpValid  = 1'b0;
    w_OpSel    = 1'b0;
    w_B        = '0;
    w_HIWrite  = 1'b0;
    w_LOWrite  = 1'b0;
    w_WData    = '0;
    w_MultStop = 1'b0;
    w_DivStop  = 1'b0;
    w_MULTHI   = '0;
    w_MULTLO   = '0;
    w_DIVHI    = '0;
    w_DIVLO    = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"},
        {58'd0, w_MultStart, w_DivStart, w_Busy, w_Done, w_DivZero, w_Timeout}, 64'd0);
    chk({tag, "_hilo"}, {w_HI, w_LO}, 64'd0);
  endtask

  // MTHI/MTLO issued in IDLE.
  task automatic write_direct(input bit whi, input bit wlo, input logic [31:0] data);
    w_HIWrite = whi;
    w_LOWrite = wlo;
    w_WData   = data;
    tick();
    w_HIWrite = 1'b0;
    w_LOWrite = 1'b0;
    if (whi) m_hi = data;
    if (wlo) m_lo = data;
    chk("mt_hilo", {w_HI, w_LO}, {m_hi, m_lo});
    chk("mt_busy", 64'(w_Busy), 64'd0);
  endtask

  // One request. delay < 0 means the mock unit never answers. Otherwise the
  // unit raises stop in the (delay+1)-th cycle after the start pulse.
  // Cycle 1 is the cycle after acceptance.
  task automatic run_op(input bit sel, input logic [31:0] b, input int delay,
                        input logic [31:0] rhi, input logic [31:0] rlo,
                        input bit whi, input bit wlo, input logic [31:0] wdata);
    bit          dz, ok, to, finished, stop_now;
    int          exp_busy, c;
    int          busy_n, ms_n, ds_n, done_n, dz_n, to_n;
    int          start_c, done_c, dz_c, to_c;
    logic [31:0] e_hi, e_lo;

    // Expected outcome, from the operation rules.
    dz       = sel && (b == 32'd0);
    ok       = !dz && (delay >= 0) && (delay <= TIMEOUT - 1);
    to       = !dz && !ok;
    exp_busy = dz ? 1 : (ok ? delay + 3 : TIMEOUT + 2);
    e_hi = m_hi;
    e_lo = m_lo;
    if (whi) e_hi = wdata;
    if (wlo) e_lo = wdata;
    if (ok) begin
      e_hi = rhi;
      e_lo = rlo;
    end

    w_OpValid = 1'b1;
    w_OpSel   = sel;
    w_B       = b;
    w_HIWrite = whi;
    w_LOWrite = wlo;
    w_WData   = wdata;
    tick();
    w_OpValid = 1'b0;
    w_HIWrite = 1'b0;
    w_LOWrite = 1'b0;

    busy_n = 0; ms_n = 0; ds_n = 0; done_n = 0; dz_n = 0; to_n = 0;
    start_c = -1; done_c = -1; dz_c = -1; to_c = -1;
    finished = 1'b0;
    c = 1;
    while (!finished && c <= BUDGET) begin
      if (w_Busy) busy_n++;
      if (w_MultStart) begin ms_n++; start_c = c; end
      if (w_DivStart)  begin ds_n++; start_c = c; end
      if (w_Done) begin
        done_n++;
        done_c = c;
        chk("done_hilo", {w_HI, w_LO}, {e_hi, e_lo});
      end
      if (w_DivZero) begin dz_n++; dz_c = c; end
      if (w_Timeout) begin to_n++; to_c = c; end

      if (!w_Busy) begin
        finished = 1'b1;
        quiet_inputs();
      end else begin
        // Mock units. The foreign stop flag and stray requests/writes are noise.
        stop_now = (delay >= 0) && (c == delay + 2);
        w_MULTHI = $urandom;
        w_MULTLO = $urandom;
        w_DIVHI  = $urandom;
        w_DIVLO  = $urandom;
        if (sel) begin
          w_DivStop  = stop_now;
          w_MultStop = 1'($urandom_range(0, 1));
          if (stop_now) begin w_DIVHI = rhi; w_DIVLO = rlo; end
        end else begin
          w_MultStop = stop_now;
          w_DivStop  = 1'($urandom_range(0, 1));
          if (stop_now) begin w_MULTHI = rhi; w_MULTLO = rlo; end
        end
        w_OpValid = 1'($urandom_range(0, 1));
        w_OpSel   = 1'($urandom_range(0, 1));
        w_B       = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
        w_HIWrite = 1'($urandom_range(0, 1));
        w_LOWrite = 1'($urandom_range(0, 1));
        w_WData   = ($urandom_range(0, 1) == 0) ? 32'h0000ABCD : $urandom;
        tick();
        c++;
      end
    end
    if (!finished) quiet_inputs();

    chk("op_returned_idle", 64'(finished), 64'd1);
    chk("busy_cycles", 64'(busy_n), 64'(exp_busy));
    chk("mult_start_cnt", 64'(ms_n), 64'((!dz && !sel) ? 1 : 0));
    chk("div_start_cnt", 64'(ds_n), 64'((!dz && sel) ? 1 : 0));
    chk("start_cycle", 64'(start_c), 64'(dz ? -1 : 1));
    chk("done_cnt", 64'(done_n), 64'(ok ? 1 : 0));
    chk("done_cycle", 64'(done_c), 64'(ok ? delay + 3 : -1));
    chk("divzero_cnt", 64'(dz_n), 64'(dz ? 1 : 0));
    chk("divzero_cycle", 64'(dz_c), 64'(dz ? 1 : -1));
    chk("timeout_cnt", 64'(to_n), 64'(to ? 1 : 0));
    chk("timeout_cycle", 64'(to_c), 64'(to ? TIMEOUT + 2 : -1));
    chk("final_hilo", {w_HI, w_LO}, {e_hi, e_lo});
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  // Reset pulled low in the 5th WAIT cycle of a MULT. A stop afterwards must
  // not touch HI/LO.
  task automatic reset_mid_op();
    w_OpValid = 1'b1;
    w_OpSel   = 1'b0;
    w_B       = 32'd9;
    tick();
    w_OpValid = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    chk("rst_pre_busy", 64'(w_Busy), 64'd1);
    Reset = 1'b0;
    tick();
    chk_all_zero("rst_mid");
    Reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    w_MultStop = 1'b1;
    w_DivStop  = 1'b1;
    w_MULTHI   = 32'h1234_5678;
    w_MULTLO   = 32'h9ABC_DEF0;
    w_DIVHI    = 32'h1111_2222;
    w_DIVLO    = 32'h3333_4444;
    tick();
    quiet_inputs();
    tick();
    chk("rst_stop_done", 64'(w_Done), 64'd0);
    chk_all_zero("rst_after_stop");
  endtask

  initial begin
    bit          sel, whi, wlo;
    int          delay;
    logic [31:0] b;

    quiet_inputs();
    Reset = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    Reset = 1'b1;
    tick();
    chk_all_zero("post_reset_idle");

    // MULT returning -21 after 33 cycles.
    run_op(1'b0, 32'd3, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, '0);
    // DIV 100/7 after 10 cycles: 13 busy cycles.
    run_op(1'b1, 32'd7, 10, 32'd2, 32'd14, 1'b0, 1'b0, '0);
    // Divide by zero with HI preloaded.
    write_direct(1'b1, 1'b0, 32'h5);
    run_op(1'b1, 32'd0, 3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0, '0);
    // Unit never stops.
    run_op(1'b0, 32'd5, -1, 32'h0, 32'h0, 1'b0, 1'b0, '0);
    run_op(1'b1, 32'd5, -1, 32'h0, 32'h0, 1'b0, 1'b0, '0);
    // Watchdog boundary and minimum-length operation.
    run_op(1'b0, 32'd2, TIMEOUT - 1, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0, 1'b0, '0);
    run_op(1'b1, 32'd2, TIMEOUT, 32'hA5A5_0003, 32'h5A5A_0004, 1'b0, 1'b0, '0);
    run_op(1'b0, 32'd2, 0, 32'h0000_0077, 32'h0000_0088, 1'b0, 1'b0, '0);
    // Direct writes together with an accepted request.
    run_op(1'b0, 32'd4, 5, 32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 1'b1, 32'h0F0F_0F0F);
    run_op(1'b1, 32'd0, 5, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7777_0000);
    run_op(1'b0, 32'd4, -1, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_6666);
    // Reset during WAIT.
    reset_mid_op();
    // MTLO in IDLE.
    write_direct(1'b0, 1'b1, 32'h0000_ABCD);
    write_direct(1'b1, 1'b0, 32'hFEED_0001);

    for (int i = 0; i < 40; i++) begin
      sel   = 1'($urandom_range(0, 1));
      b     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 3));
      whi   = ($urandom_range(0, 5) == 0);
      wlo   = ($urandom_range(0, 5) == 0);
      run_op(sel, b, delay, $urandom, $urandom, whi, wlo, $urandom);
      if ($urandom_range(0, 3) == 0)
        write_direct(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
